// File: rtl/ttl_shift_pkg.sv
// ttl_shift_pkg: select encodings, FSM states and shift directions for the 74x194 shift sequencer
package ttl_shift_pkg;
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_UP   = 2'b01;
    localparam logic [1:0] SEL_DOWN = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
endpackage

// File: rtl/shift_count.sv
// shift_count: loadable down-counter (clock, mr async clear, load/value, dec saturating at zero, zero flag)
module shift_count #(
    parameter int AMT_W = 4
) (
    input  logic             clock,
    input  logic             mr,
    input  logic             load,
    input  logic [AMT_W-1:0] value,
    input  logic             dec,
    output logic             zero
);
    logic [AMT_W-1:0] cnt_q;
    always_ff @(posedge clock or negedge mr)
        if (!mr) cnt_q <= '0;
        else if (load) cnt_q <= value;
        else if (dec && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    assign zero = cnt_q == '0;
endmodule

// File: rtl/ttl74x194.sv
// ttl74x194: 4-bit universal shift register (clr_n_i async clear, s_i mode, dsr_i/dsl_i serial in, d_i load, q_o[0]=QA)
module ttl74x194 (
    input  logic       clk_i,
    input  logic       clr_n_i,
    input  logic [1:0] s_i,
    input  logic       dsr_i,
    input  logic       dsl_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);
    always_ff @(posedge clk_i or negedge clr_n_i)
        if (!clr_n_i) q_o <= '0;
        else q_o <= s_i == 2'b11 ? d_i :
                    s_i == 2'b01 ? {q_o[2:0], dsr_i} :
                    s_i == 2'b10 ? {dsl_i, q_o[3:1]} : q_o;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences a 74x194 cascade through load, N single-bit shifts and result hold
// Ports: req_* request handshake, res_* result handshake, sr_* cascade control and feedback.
module shift_sequencer
    import ttl_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clock,
    input  logic             mr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic             req_rotate,
    input  logic             req_fill,
    input  logic [AMT_W-1:0] req_amount,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       sr_select,
    output logic             sr_dsr,
    output logic             sr_dsl,
    output logic [WIDTH-1:0] sr_d,
    input  logic [WIDTH-1:0] sr_q
);
    localparam logic [AMT_W-1:0] W_A = AMT_W'(WIDTH);
    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic             dir_q, rot_q, fill_q, res_valid_q, zero, accept, shifting;
    logic [1:0]       sel_q;
    logic [AMT_W-1:0] n_eff;
    assign n_eff     = req_rotate ? (req_amount & (W_A - 1'b1)) : (req_amount > W_A ? W_A : req_amount);
    // mr gates ready so it is low during reset and high in the very first cycle after release
    assign req_ready = mr && state_q == IDLE;
    assign accept    = req_valid && req_ready;
    assign shifting  = state_q == SHIFT;
    // The counter also steps on the LOAD edge, so in SHIFT zero means this edge performs the last shift
    shift_count #(.AMT_W(AMT_W)) u_count (
        .clock(clock),
        .mr   (mr),
        .load (accept),
        .value(n_eff),
        .dec  (state_q == LOAD || shifting),
        .zero (zero)
    );
    always_ff @(posedge clock or negedge mr)
        if (!mr) begin
            state_q     <= IDLE;
            data_q      <= '0;
            dir_q       <= DIR_UP;
            rot_q       <= 1'b0;
            fill_q      <= 1'b0;
            sel_q       <= SEL_HOLD;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= LOAD;
                    data_q  <= req_data;
                    dir_q   <= req_dir;
                    rot_q   <= req_rotate;
                    fill_q  <= req_fill;
                    sel_q   <= SEL_LOAD;
                end
                LOAD: begin
                    state_q     <= zero ? DONE : SHIFT;
                    sel_q       <= zero ? SEL_HOLD : (dir_q == DIR_DOWN ? SEL_DOWN : SEL_UP);
                    res_valid_q <= zero;
                end
                SHIFT: if (zero) begin
                    state_q     <= DONE;
                    sel_q       <= SEL_HOLD;
                    res_valid_q <= 1'b1;
                end
                DONE: if (res_ready) begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    assign sr_dsr    = shifting && dir_q == DIR_UP && (rot_q ? sr_q[WIDTH-1] : fill_q);
    assign sr_dsl    = shifting && dir_q == DIR_DOWN && (rot_q ? sr_q[0] : fill_q);
    assign sr_select = sel_q;
    assign sr_d      = data_q;
    assign res_valid = res_valid_q;
    assign res_data  = sr_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks of shift_sequencer driving a 74x194 cascade
module tb_shift_sequencer;
    localparam int W = 8;
    localparam int A = 4;
    logic         clock = 1'b0;
    logic         mr = 1'b0;
    logic         req_valid = 1'b0, req_ready, req_dir = 1'b0, req_rotate = 1'b0, req_fill = 1'b0;
    logic [W-1:0] req_data = '0;
    logic [A-1:0] req_amount = '0;
    logic         res_valid, res_ready = 1'b0;
    logic [W-1:0] res_data, sr_d, sr_q;
    logic [1:0]   sr_select;
    logic         sr_dsr, sr_dsl;
    int           pass_cnt = 0, total_cnt = 0;

    always #5 clock = ~clock;

    shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
        .clock(clock), .mr(mr), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_dir(req_dir), .req_rotate(req_rotate), .req_fill(req_fill), .req_amount(req_amount),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .sr_select(sr_select),
        .sr_dsr(sr_dsr), .sr_dsl(sr_dsl), .sr_d(sr_d), .sr_q(sr_q)
    );

    for (genvar k = 0; k < W / 4; k++) begin : g_dev
        ttl74x194 u_dev (
            .clk_i  (clock),
            .clr_n_i(mr),
            .s_i    (sr_select),
            .dsr_i  (k == 0 ? sr_dsr : sr_q[4*k-1]),
            .dsl_i  (k == W / 4 - 1 ? sr_dsl : sr_q[4*k+4 < W ? 4*k+4 : 0]),
            .d_i    (sr_d[4*k+:4]),
            .q_o    (sr_q[4*k+:4])
        );
    end

    function automatic int eff_n(input logic rot, input int amt);
        return rot ? amt % W : (amt > W ? W : amt);
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] data, input logic dir, rot, fill, input int amt);
        int unsigned v, mask, n, fb, r;
        v    = data;
        mask = (1 << W) - 1;
        n    = eff_n(rot, amt);
        fb   = fill ? (1 << n) - 1 : 0;
        if (rot) r = dir ? ((v >> n) | (v << (W - n))) : ((v << n) | (v >> (W - n)));
        else     r = dir ? ((v >> n) | (fb << (W - n))) : ((v << n) | fb);
        return W'(r & mask);
    endfunction

    task automatic do_op(input logic [W-1:0] data, input logic dir, rot, fill, input logic [A-1:0] amt,
                         input int exp_n, input logic [W-1:0] exp_res, input int hold);
        int waited = 0;
        logic [1:0] exp_sel;
        exp_sel = dir ? 2'b10 : 2'b01;
        while (!req_ready && waited < 20) begin
            @(posedge clock); #1;
            waited++;
        end
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
        else pass_cnt++;
        req_valid = 1'b1; req_data = data; req_dir = dir; req_rotate = rot; req_fill = fill; req_amount = amt;
        @(posedge clock); #1;
        req_valid = 1'b0;
        total_cnt++;
        if ({sr_select, sr_d} !== {2'b11, data}) $display("FAIL load: sel=%b d=%h required sel=11 d=%h", sr_select, sr_d, data);
        else pass_cnt++;
        for (int i = 0; i < exp_n; i++) begin
            @(posedge clock); #1;
            total_cnt++;
            if ({res_valid, sr_select} !== {1'b0, exp_sel})
                $display("FAIL shift_cycle%0d: valid=%b sel=%b required valid=0 sel=%b", i, res_valid, sr_select, exp_sel);
            else pass_cnt++;
        end
        @(posedge clock); #1;
        total_cnt++;
        if ({res_valid, sr_select, req_ready} !== {1'b1, 2'b00, 1'b0})
            $display("FAIL done_state: valid=%b sel=%b ready=%b required 1/00/0", res_valid, sr_select, req_ready);
        else pass_cnt++;
        total_cnt++;
        if (res_data !== exp_res) $display("FAIL result: res_data=%h required %h (data=%h dir=%b rot=%b fill=%b amt=%0d)", res_data, exp_res, data, dir, rot, fill, amt);
        else pass_cnt++;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_data  = ~data;
            @(posedge clock); #1;
            total_cnt++;
            if ({res_valid, sr_select, req_ready, res_data} !== {1'b1, 2'b00, 1'b0, exp_res})
                $display("FAIL backpressure%0d: valid=%b sel=%b ready=%b data=%h required 1/00/0/%h", h, res_valid, sr_select, req_ready, res_data, exp_res);
            else pass_cnt++;
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0;
        total_cnt++;
        if ({res_valid, req_ready, sr_select} !== {1'b0, 1'b1, 2'b00})
            $display("FAIL handoff: valid=%b ready=%b sel=%b required 0/1/00", res_valid, req_ready, sr_select);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        mr = 1'b0;
        req_valid = 1'b1;
        req_data = 8'hA5;
        repeat (3) begin
            @(posedge clock); #1;
        end
        total_cnt++;
        if ({req_ready, res_valid, sr_select, sr_dsr, sr_dsl, sr_d, sr_q} !== '0)
            $display("FAIL reset_outputs: ready=%b valid=%b sel=%b dsr=%b dsl=%b d=%h q=%h required all 0", req_ready, res_valid, sr_select, sr_dsr, sr_dsl, sr_d, sr_q);
        else pass_cnt++;
        req_valid = 1'b0;
        mr = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_release: req_ready=%b required 1", req_ready);
        else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++;
        if ({req_ready, sr_select} !== {1'b1, 2'b00}) $display("FAIL reset_no_accept: ready=%b sel=%b required 1/00", req_ready, sr_select);
        else pass_cnt++;
    endtask

    task automatic test_directed;
        do_op(8'h81, 1'b0, 1'b0, 1'b0, 4'd3, 3, 8'h08, 0);
        do_op(8'h81, 1'b1, 1'b1, 1'b0, 4'd1, 1, 8'hC0, 0);
        do_op(8'h81, 1'b1, 1'b1, 1'b0, 4'd9, 1, 8'hC0, 0);
        do_op(8'h5A, 1'b0, 1'b0, 1'b0, 4'd0, 0, 8'h5A, 0);
        do_op(8'h00, 1'b1, 1'b0, 1'b1, 4'd12, 8, 8'hFF, 0);
        do_op(8'h01, 1'b0, 1'b1, 1'b0, 4'd12, 4, 8'h10, 0);
    endtask

    task automatic test_backpressure;
        do_op(8'h3C, 1'b0, 1'b1, 1'b0, 4'd2, 2, 8'hF0, 5);
    endtask

    task automatic test_abort;
        logic seen = 1'b0;
        req_valid = 1'b1; req_data = 8'hFF; req_dir = 1'b0; req_rotate = 1'b0; req_fill = 1'b0; req_amount = 4'd5;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        mr = 1'b0;
        #1;
        total_cnt++;
        if ({sr_select, res_valid, req_ready, sr_d} !== '0)
            $display("FAIL abort_reset: sel=%b valid=%b ready=%b d=%h required all 0", sr_select, res_valid, req_ready, sr_d);
        else pass_cnt++;
        #1 mr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (res_valid) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort_no_result: res_valid seen=%b required 0", seen);
        else pass_cnt++;
        total_cnt++;
        if ({req_ready, sr_select} !== {1'b1, 2'b00}) $display("FAIL abort_idle: ready=%b sel=%b required 1/00", req_ready, sr_select);
        else pass_cnt++;
    endtask

    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] d;
            logic dr, ro, fi;
            logic [A-1:0] am;
            d  = W'($urandom);
            dr = 1'($urandom);
            ro = 1'($urandom);
            fi = 1'($urandom);
            am = A'($urandom);
            do_op(d, dr, ro, fi, am, eff_n(ro, int'(am)), model(d, dr, ro, fi, int'(am)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_abort;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
